// File: rtl/gather8x2.sv
`default_nettype none
// gather8x2: gathers WIDTH-bit words into an 8-lane frame and presents it as
// registered lanes O0..O7 with zero padding. Define GATHER8X2_LAST_EN to add I_last.
module gather8x2 #(
  parameter int WIDTH = 2
) (
  input  logic             CLK,
  input  logic             ASYNCRESETN,
  input  logic [WIDTH-1:0] I_data,
  input  logic             I_valid,
`ifdef GATHER8X2_LAST_EN
  input  logic             I_last,
`endif
  output logic             I_ready,
  output logic [WIDTH-1:0] O0,
  output logic [WIDTH-1:0] O1,
  output logic [WIDTH-1:0] O2,
  output logic [WIDTH-1:0] O3,
  output logic [WIDTH-1:0] O4,
  output logic [WIDTH-1:0] O5,
  output logic [WIDTH-1:0] O6,
  output logic [WIDTH-1:0] O7,
  output logic [3:0]       O_count,
  output logic             O_valid,
  input  logic             O_ready
);

  logic [WIDTH-1:0] fill [8];
  logic [WIDTH-1:0] lane [8];
  logic [3:0]       cnt;
  logic             full;

  logic             xfer;
  logic             accept;
  logic             close;
  logic [2:0]       base;
  logic [3:0]       cnt_next;

  assign xfer     = full && (!O_valid || O_ready);
  assign I_ready  = !full || xfer;
  assign accept   = I_valid && I_ready;
  // cnt only reaches 8 while full, so a non-full fill always fits in 3 bits.
  assign base     = xfer ? 3'd0 : cnt[2:0];
  assign cnt_next = {1'b0, base} + 4'd1;

`ifdef GATHER8X2_LAST_EN
  assign close = (cnt_next == 4'd8) || I_last;
`else
  assign close = (cnt_next == 4'd8);
`endif

  always_ff @(posedge CLK or negedge ASYNCRESETN) begin
    if (!ASYNCRESETN) begin
      cnt  <= 4'd0;
      full <= 1'b0;
      for (int i = 0; i < 8; i++) fill[i] <= '0;
    end else begin
      if (xfer) begin
        cnt  <= 4'd0;
        full <= 1'b0;
        for (int i = 0; i < 8; i++) fill[i] <= '0;
      end
      // A word accepted alongside xfer starts the next frame in lane 0.
      if (accept) begin
        fill[base] <= I_data;
        cnt        <= cnt_next;
        full       <= close;
      end
    end
  end

  always_ff @(posedge CLK or negedge ASYNCRESETN) begin
    if (!ASYNCRESETN) begin
      O_count <= 4'd0;
      O_valid <= 1'b0;
      for (int i = 0; i < 8; i++) lane[i] <= '0;
    end else if (xfer) begin
      O_count <= cnt;
      O_valid <= 1'b1;
      for (int i = 0; i < 8; i++) lane[i] <= (4'(i) < cnt) ? fill[i] : '0;
    end else if (O_ready) begin
      O_valid <= 1'b0;
    end
  end

  assign O0 = lane[0];
  assign O1 = lane[1];
  assign O2 = lane[2];
  assign O3 = lane[3];
  assign O4 = lane[4];
  assign O5 = lane[5];
  assign O6 = lane[6];
  assign O7 = lane[7];

endmodule
`default_nettype wire

// File: doc/gather8x2.md
# gather8x2

Upstream feeder for the 8-input, 2-bit XOR fold stage. Collects a stream of 2-bit words through a valid/ready handshake into a frame of eight lanes. Presents the frame as eight parallel registered words (`O0`..`O7`) with its own valid/ready handshake. Unfilled lanes are zero, the XOR identity, so short frames fold correctly downstream.

## Interface
Parameters:
- `WIDTH`, default 2: bits per lane word. Lane count is fixed at 8.

Ports:
- `CLK`  in  1  clock; all state changes on the rising edge.
- `ASYNCRESETN`  in  1  reset, asynchronous assert, active-low.
- `I_data`  in  WIDTH  input word.
- `I_valid`  in  1  input word offered.
- `I_last`  in  1  final word of a frame; present only with `GATHER8X2_LAST_EN`.
- `I_ready`  out  1  gatherer accepts `I_data` this cycle.
- `O0`..`O7`  out  WIDTH each  frame lanes; `O0` holds the first word of the frame.
- `O_count`  out  4  number of real words in the frame, 1..8.
- `O_valid`  out  1  frame on `O*` is valid.
- `O_ready`  in  1  downstream consumes the frame.

## Operation
- Input accept: `I_valid && I_ready` at an edge.
- Frame handoff: `O_valid && O_ready` at an edge.
- Fill stage state:
  - `fill[0..7]`: lane registers.
  - `cnt`: 0..8, number of words held.
  - `full`: frame complete.
- Output stage: `O0`..`O7`, `O_count`, `O_valid`, all registered.
- On accept: `fill[cnt] <= I_data` and `cnt <= cnt+1`. `full <= 1` when the new `cnt` is 8, or when `I_last=1` (LAST_EN builds).
- `xfer = full && (!O_valid || O_ready)`.
- On `xfer`:
  - Output lanes take `fill`; lanes at index ≥ `cnt` are driven 0.
  - `O_count <= cnt`; `O_valid <= 1`.
  - Fill is cleared: `cnt <= 0`, `full <= 0`, lanes set to 0.
- `O_valid` clears on a handoff unless `xfer` occurs in the same cycle.
- `I_ready = !full || xfer`. Combinational, from registered state and `O_ready` only; it never depends on `I_valid`.
- Accept and `xfer` in the same cycle: the accepted word lands in lane 0 of the new frame and `cnt <= 1`. With LAST_EN and `I_last=1`, `full <= 1` again.
- No overflow path: with `full=1` and output stalled, `I_ready=0` and `I_data` is ignored.
- `I_last` is ignored unless the beat is accepted.
- Output stage holds all `O*` stable while `O_valid && !O_ready`.

## Timing
- Reset values (async, immediate):
  - `O0`..`O7` = 0, `O_count` = 0, `O_valid` = 0.
  - `cnt` = 0, `full` = 0, so `I_ready` = 1.
- Latency: completing word accepted at edge n, then `full=1` in cycle n+1, then `xfer` at edge n+1 if the output is free, then `O_valid=1` from cycle n+2.
- Sustained throughput with `O_ready` held high:
  - One word per cycle, no bubbles.
  - 8-word frames every 8 cycles.
  - One-word frames (`I_last` every beat) every cycle.
- Backpressure: if `O_ready=0` with the output full, the next frame completes in fill. `I_ready` then drops from the cycle after completion until the cycle the output frees.
- Reset mid-frame discards both the partial fill and any pending output frame. No frame is emitted for pre-reset words.

## Configuration
- `GATHER8X2_LAST_EN` defined:
  - `I_last` port exists; frames close early on `I_last`.
  - `O_count` ranges 1..8.
- Not defined:
  - `I_last` port is absent; every frame is exactly 8 words.
  - `O_count` is constant 8 whenever `O_valid=1`; it is 0 after reset.

## Test plan
- Reset, then 8 words 1,2,3,0,1,2,3,0 with `O_ready=1` → after edge n+1, `O0..O7`=1,2,3,0,1,2,3,0, `O_count`=8, `O_valid`=1 for one cycle; `I_ready` stays 1 throughout.
- LAST_EN: 3 words 3,1,2 with `I_last` on the 3rd → `O0..O2`=3,1,2, `O3..O7`=0, `O_count`=3; downstream fold result = 0.
- `O_ready=0`, feed 16 words continuously → first frame held stable; `I_ready`=0 from the cycle after word 16 is accepted. Raise `O_ready` → frame 1 hands off and frame 2 transfers on the same edge; `I_ready` returns to 1 that cycle.
- Back-to-back: 24 words continuous with `O_ready=1` → three frames, `O_valid` high in three single cycles spaced 8 cycles apart, no input stall.
- Assert `ASYNCRESETN=0` mid-cycle after 5 words, with an output frame pending → all outputs 0 immediately. After release, an 8-word frame emits only post-reset words.
- LAST_EN: `I_last=1` on every beat with `O_ready=1`, words 1,2,3 → three frames on consecutive cycles, each with `O_count`=1 and `O0`=1,2,3 respectively.
